// File: rtl/pong_pkg.sv
// Shared pong geometry, timing constants and FSM encoding.
// The graphics renderer also imports this package.
package pong_pkg;

  localparam int CANVAS_TOP    = 50;
  localparam int CANVAS_BOTTOM = 450;
  localparam int CANVAS_LEFT   = 50;
  localparam int CANVAS_RIGHT  = 600;
  localparam int BALL_SIZE     = 10;
  localparam int PADDLE_OFFSET = 20;
  localparam int PADDLE_WIDTH  = 10;
  localparam int PADDLE_HEIGHT = 50;
  localparam int SPEED_X       = 4;
  localparam int SPEED_Y       = 2;
  localparam int SERVE_FRAMES  = 60;
  localparam int POINT_FRAMES  = 30;
  localparam int WIN_SCORE     = 9;

  // Paddle faces the ball collides with
  localparam int LF = CANVAS_LEFT + PADDLE_OFFSET + PADDLE_WIDTH;
  localparam int RF = CANVAS_RIGHT - PADDLE_OFFSET - PADDLE_WIDTH;

  localparam logic [9:0] CENTRE_X = 10'((CANVAS_LEFT + CANVAS_RIGHT - BALL_SIZE) / 2);
  localparam logic [9:0] CENTRE_Y = 10'((CANVAS_TOP + CANVAS_BOTTOM - BALL_SIZE) / 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/ball_collide.sv
// Combinational one-frame ball step: wall bounce, paddle bounce, miss detection.
// Compares are done on 11-bit zero-extended values so nothing wraps.
module ball_collide
  import pong_pkg::*;
(
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_dir_x,
  input  logic       i_dir_y,
  input  logic [9:0] i_paddle_left_y,
  input  logic [9:0] i_paddle_right_y,
  output logic [9:0] o_nx,
  output logic [9:0] o_ny,
  output logic       o_ndir_x,
  output logic       o_ndir_y,
  output logic       o_hit_left,
  output logic       o_hit_right,
  output logic       o_miss_left,
  output logic       o_miss_right
);

  logic [10:0] w_x, w_y, w_pl, w_pr, w_ny_ext;
  logic [9:0]  w_ny;
  logic        w_ovl, w_ovr;

  assign w_x  = {1'b0, i_x};
  assign w_y  = {1'b0, i_y};
  assign w_pl = {1'b0, i_paddle_left_y};
  assign w_pr = {1'b0, i_paddle_right_y};

  always_comb begin
    w_ny     = i_y;
    o_ndir_y = i_dir_y;
    if (i_dir_y) begin
      if (w_y + 11'(SPEED_Y + BALL_SIZE) >= 11'(CANVAS_BOTTOM)) begin
        w_ny     = 10'(CANVAS_BOTTOM - BALL_SIZE);
        o_ndir_y = 1'b0;
      end else begin
        w_ny = i_y + 10'(SPEED_Y);
      end
    end else begin
      if (w_y <= 11'(CANVAS_TOP + SPEED_Y)) begin
        w_ny     = 10'(CANVAS_TOP);
        o_ndir_y = 1'b1;
      end else begin
        w_ny = i_y - 10'(SPEED_Y);
      end
    end
  end

  assign o_ny     = w_ny;
  assign w_ny_ext = {1'b0, w_ny};

  // Paddle overlap uses the post-wall y
  assign w_ovl = (w_ny_ext + 11'(BALL_SIZE) > w_pl) && (w_ny_ext < w_pl + 11'(PADDLE_HEIGHT));
  assign w_ovr = (w_ny_ext + 11'(BALL_SIZE) > w_pr) && (w_ny_ext < w_pr + 11'(PADDLE_HEIGHT));

  always_comb begin
    o_nx         = i_x;
    o_ndir_x     = i_dir_x;
    o_hit_left   = 1'b0;
    o_hit_right  = 1'b0;
    o_miss_left  = 1'b0;
    o_miss_right = 1'b0;
    if (i_dir_x) begin
      if ((w_x + 11'(BALL_SIZE) < 11'(RF)) &&
          (w_x + 11'(SPEED_X + BALL_SIZE) >= 11'(RF)) && w_ovr) begin
        o_nx        = 10'(RF - BALL_SIZE);
        o_ndir_x    = 1'b0;
        o_hit_right = 1'b1;
      end else if (w_x + 11'(SPEED_X + BALL_SIZE) >= 11'(CANVAS_RIGHT)) begin
        o_nx         = 10'(CANVAS_RIGHT - BALL_SIZE);
        o_miss_right = 1'b1;
      end else begin
        o_nx = i_x + 10'(SPEED_X);
      end
    end else begin
      if ((w_x > 11'(LF)) && (w_x <= 11'(LF + SPEED_X)) && w_ovl) begin
        o_nx       = 10'(LF);
        o_ndir_x   = 1'b1;
        o_hit_left = 1'b1;
      end else if (w_x <= 11'(CANVAS_LEFT + SPEED_X)) begin
        o_nx        = 10'(CANVAS_LEFT);
        o_miss_left = 1'b1;
      end else begin
        o_nx = i_x - 10'(SPEED_X);
      end
    end
  end

endmodule

// File: rtl/ball_engine.sv
// Per-frame ball physics, scoring and serve/point/game-over sequencing for pong.
// state | meaning: IDLE ball centred | SERVE hold before play | PLAY ball moving | POINT frozen after miss | OVER game won
module ball_engine
  import pong_pkg::*;
(
  input  logic       frame_clk,
  input  logic       reset,
  input  logic       start_game,
  input  logic [9:0] paddle_left_y,
  input  logic [9:0] paddle_right_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_dir_x,
  output logic       ball_dir_y,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       point_scored,
  output logic       game_running,
  output logic       game_over,
  output logic [2:0] state
);

  state_t     r_state, w_state;
  logic [9:0] r_x, r_y, w_x, w_y;
  logic       r_dx, r_dy, w_dx, w_dy;
  logic [3:0] r_sl, r_sr, w_sl, w_sr;
  logic [5:0] r_cnt, w_cnt;
  logic       r_ps, w_ps, r_run, r_over;
  logic       r_left_scored, w_left_scored;

  logic [9:0] w_cx, w_cy;
  logic       w_cdx, w_cdy, w_hit_l, w_hit_r, w_miss_l, w_miss_r;

  ball_collide u_collide (
    .i_x              (r_x),
    .i_y              (r_y),
    .i_dir_x          (r_dx),
    .i_dir_y          (r_dy),
    .i_paddle_left_y  (paddle_left_y),
    .i_paddle_right_y (paddle_right_y),
    .o_nx             (w_cx),
    .o_ny             (w_cy),
    .o_ndir_x         (w_cdx),
    .o_ndir_y         (w_cdy),
    .o_hit_left       (w_hit_l),
    .o_hit_right      (w_hit_r),
    .o_miss_left      (w_miss_l),
    .o_miss_right     (w_miss_r)
  );

  always_comb begin
    w_state       = r_state;
    w_x           = r_x;
    w_y           = r_y;
    w_dx          = r_dx;
    w_dy          = r_dy;
    w_sl          = r_sl;
    w_sr          = r_sr;
    w_cnt         = r_cnt;
    w_ps          = 1'b0;
    w_left_scored = r_left_scored;
    if (!start_game) begin
      w_state = ST_IDLE;
      w_x     = CENTRE_X;
      w_y     = CENTRE_Y;
      w_sl    = 4'd0;
      w_sr    = 4'd0;
      w_cnt   = 6'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_x     = CENTRE_X;
          w_y     = CENTRE_Y;
          w_cnt   = 6'(SERVE_FRAMES);
          w_state = ST_SERVE;
        end
        ST_SERVE: begin
          if (r_cnt <= 6'd1) begin
            w_cnt   = 6'd0;
            w_state = ST_PLAY;
          end else begin
            w_cnt = r_cnt - 6'd1;
          end
        end
        ST_PLAY: begin
          w_x  = w_cx;
          w_y  = w_cy;
          w_dx = w_cdx;
          w_dy = w_cdy;
          if (w_miss_r && !w_hit_r) begin
            w_sl          = sat_inc(r_sl);
            w_left_scored = 1'b1;
            w_cnt         = 6'(POINT_FRAMES);
            w_ps          = 1'b1;
            w_state       = ST_POINT;
          end else if (w_miss_l && !w_hit_l) begin
            w_sr          = sat_inc(r_sr);
            w_left_scored = 1'b0;
            w_cnt         = 6'(POINT_FRAMES);
            w_ps          = 1'b1;
            w_state       = ST_POINT;
          end
        end
        ST_POINT: begin
          if (r_cnt <= 6'd1) begin
            w_cnt = 6'd0;
            if ((r_left_scored ? r_sl : r_sr) == 4'(WIN_SCORE)) begin
              w_state = ST_OVER;
            end else begin
              // Re-serve toward the left after a left point, toward the right otherwise
              w_x     = CENTRE_X;
              w_y     = CENTRE_Y;
              w_dx    = ~r_left_scored;
              w_cnt   = 6'(SERVE_FRAMES);
              w_state = ST_SERVE;
            end
          end else begin
            w_cnt = r_cnt - 6'd1;
          end
        end
        ST_OVER: begin
        end
        default: w_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge frame_clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_x           <= CENTRE_X;
      r_y           <= CENTRE_Y;
      r_dx          <= 1'b1;
      r_dy          <= 1'b1;
      r_sl          <= 4'd0;
      r_sr          <= 4'd0;
      r_cnt         <= 6'd0;
      r_ps          <= 1'b0;
      r_run         <= 1'b0;
      r_over        <= 1'b0;
      r_left_scored <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_x           <= w_x;
      r_y           <= w_y;
      r_dx          <= w_dx;
      r_dy          <= w_dy;
      r_sl          <= w_sl;
      r_sr          <= w_sr;
      r_cnt         <= w_cnt;
      r_ps          <= w_ps;
      r_run         <= (w_state == ST_PLAY);
      r_over        <= (w_state == ST_OVER);
      r_left_scored <= w_left_scored;
    end
  end

  assign ball_x       = r_x;
  assign ball_y       = r_y;
  assign ball_dir_x   = r_dx;
  assign ball_dir_y   = r_dy;
  assign score_left   = r_sl;
  assign score_right  = r_sr;
  assign point_scored = r_ps;
  assign game_running = r_run;
  assign game_over    = r_over;
  assign state        = r_state;

endmodule

// File: tb/tb_ball_engine.sv
// Scoreboard bench for ball_engine: a frame-level reference model pushes the
// expected outputs for each frame, which are popped and compared after the edge.
module tb_ball_engine;

  logic       frame_clk, reset, start_game;
  logic [9:0] paddle_left_y, paddle_right_y;
  logic [9:0] ball_x, ball_y;
  logic       ball_dir_x, ball_dir_y;
  logic [3:0] score_left, score_right;
  logic       point_scored, game_running, game_over;
  logic [2:0] state;

  ball_engine dut (
    .frame_clk      (frame_clk),
    .reset          (reset),
    .start_game     (start_game),
    .paddle_left_y  (paddle_left_y),
    .paddle_right_y (paddle_right_y),
    .ball_x         (ball_x),
    .ball_y         (ball_y),
    .ball_dir_x     (ball_dir_x),
    .ball_dir_y     (ball_dir_y),
    .score_left     (score_left),
    .score_right    (score_right),
    .point_scored   (point_scored),
    .game_running   (game_running),
    .game_over      (game_over),
    .state          (state)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int x, y, dx, dy, sl, sr, ps, run, over, st;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  int m_x, m_y, m_dx, m_dy, m_sl, m_sr, m_ps, m_st, m_cnt, m_last_left;
  bit saw_top, saw_bottom;

  localparam int TRACK = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 320; m_y = 245; m_dx = 1; m_dy = 1;
    m_sl = 0; m_sr = 0; m_ps = 0; m_st = 0; m_cnt = 0; m_last_left = 0;
  endtask

  task automatic model_step(input bit st, input int pl, input int pr);
    int nx, ny, ndx, ndy;
    bit ovl, ovr, miss_r, miss_l;
    m_ps = 0;
    if (!st) begin
      m_st = 0; m_sl = 0; m_sr = 0; m_x = 320; m_y = 245; m_cnt = 0;
    end else begin
      case (m_st)
        0: begin m_x = 320; m_y = 245; m_cnt = 60; m_st = 1; end
        1: if (m_cnt <= 1) begin m_cnt = 0; m_st = 2; end else m_cnt--;
        2: begin
          ny = m_y; ndy = m_dy; nx = m_x; ndx = m_dx; miss_r = 0; miss_l = 0;
          if (m_dy == 1) begin
            if (m_y + 12 >= 450) begin ny = 440; ndy = 0; end else ny = m_y + 2;
          end else begin
            if (m_y <= 52) begin ny = 50; ndy = 1; end else ny = m_y - 2;
          end
          ovl = (ny + 10 > pl) && (ny < pl + 50);
          ovr = (ny + 10 > pr) && (ny < pr + 50);
          if (m_dx == 1) begin
            if (m_x + 10 < 570 && m_x + 14 >= 570 && ovr) begin nx = 560; ndx = 0; end
            else if (m_x + 14 >= 600) begin nx = 590; miss_r = 1; end
            else nx = m_x + 4;
          end else begin
            if (m_x > 80 && m_x <= 84 && ovl) begin nx = 80; ndx = 1; end
            else if (m_x <= 54) begin nx = 50; miss_l = 1; end
            else nx = m_x - 4;
          end
          m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
          if (miss_r || miss_l) begin
            if (miss_r) begin m_sl = (m_sl < 15) ? m_sl + 1 : 15; m_last_left = 1; end
            else        begin m_sr = (m_sr < 15) ? m_sr + 1 : 15; m_last_left = 0; end
            m_cnt = 30; m_ps = 1; m_st = 3;
          end
        end
        3: begin
          if (m_cnt <= 1) begin
            m_cnt = 0;
            if ((m_last_left ? m_sl : m_sr) == 9) m_st = 4;
            else begin
              m_x = 320; m_y = 245; m_dx = m_last_left ? 0 : 1; m_cnt = 60; m_st = 1;
            end
          end else m_cnt--;
        end
        default: ;
      endcase
    end
  endtask

  // One frame: drive at negedge, predict, let the edge happen, compare at next negedge
  task automatic frame(input bit st, input int lmode, input int rmode);
    exp_t e, g;
    int pl, pr;
    pl = (lmode == TRACK) ? ((m_y >= 20) ? m_y - 20 : 0) : lmode;
    pr = (rmode == TRACK) ? ((m_y >= 20) ? m_y - 20 : 0) : rmode;
    start_game = st; paddle_left_y = 10'(pl); paddle_right_y = 10'(pr);
    model_step(st, pl, pr);
    e.x = m_x; e.y = m_y; e.dx = m_dx; e.dy = m_dy; e.sl = m_sl; e.sr = m_sr;
    e.ps = m_ps; e.run = (m_st == 2) ? 1 : 0; e.over = (m_st == 4) ? 1 : 0; e.st = m_st;
    sb.push_back(e);
    @(negedge frame_clk);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      g = sb.pop_front();
      chk("ball_x", ball_x, g.x);
      chk("ball_y", ball_y, g.y);
      chk("dir_x", ball_dir_x, g.dx);
      chk("dir_y", ball_dir_y, g.dy);
      chk("score_left", score_left, g.sl);
      chk("score_right", score_right, g.sr);
      chk("point_scored", point_scored, g.ps);
      chk("game_running", game_running, g.run);
      chk("game_over", game_over, g.over);
      chk("state", state, g.st);
    end
    if (ball_y == 10'd50)  saw_top = 1;
    if (ball_y == 10'd440) saw_bottom = 1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, ball_x, 320);
    chk({tag, "_y"}, ball_y, 245);
    chk({tag, "_dx"}, ball_dir_x, 1);
    chk({tag, "_dy"}, ball_dir_y, 1);
    chk({tag, "_sl"}, score_left, 0);
    chk({tag, "_sr"}, score_right, 0);
    chk({tag, "_ps"}, point_scored, 0);
    chk({tag, "_run"}, game_running, 0);
    chk({tag, "_over"}, game_over, 0);
    chk({tag, "_state"}, state, 0);
  endtask

  initial begin
    int n;
    saw_top = 0; saw_bottom = 0;
    reset = 1'b1; start_game = 1'b0; paddle_left_y = '0; paddle_right_y = '0;
    model_reset();
    #2;
    chk_reset_vals("reset");
    @(negedge frame_clk);
    reset = 1'b0;

    repeat (2) frame(0, TRACK, 340);
    repeat (61) frame(1, TRACK, 340);
    chk("serve_done_state", state, 2);
    chk("serve_done_x", ball_x, 320);
    frame(1, TRACK, 340);
    chk("first_play_x", ball_x, 324);
    chk("first_play_y", ball_y, 247);
    repeat (59) frame(1, TRACK, 340);
    chk("rhit_x", ball_x, 560);
    chk("rhit_y", ball_y, 365);
    chk("rhit_dx", ball_dir_x, 0);
    frame(1, TRACK, 340);
    chk("after_rhit_x", ball_x, 556);

    repeat (400) frame(1, TRACK, TRACK);
    chk("wall_bottom_seen", saw_bottom, 1);
    chk("wall_top_seen", saw_top, 1);

    n = 0;
    while (m_st != 3 && n < 600) begin frame(1, TRACK, 1000); n++; end
    chk("rmiss_state", state, 3);
    chk("rmiss_x", ball_x, 590);
    chk("rmiss_score_left", score_left, 1);
    chk("rmiss_pulse", point_scored, 1);
    repeat (30) frame(1, TRACK, 1000);
    chk("reserve_state", state, 1);
    chk("reserve_x", ball_x, 320);
    chk("reserve_y", ball_y, 245);
    chk("reserve_dx", ball_dir_x, 0);

    n = 0;
    while (m_st != 3 && n < 600) begin frame(1, 1000, TRACK); n++; end
    chk("lmiss_state", state, 3);
    chk("lmiss_x", ball_x, 50);
    chk("lmiss_score_right", score_right, 1);
    repeat (30) frame(1, 1000, TRACK);
    chk("lreserve_dx", ball_dir_x, 1);

    n = 0;
    while (m_st != 4 && n < 5000) begin frame(1, TRACK, 1000); n++; end
    chk("over_state", state, 4);
    chk("over_flag", game_over, 1);
    chk("over_score_left", score_left, 9);
    repeat (5) frame(1, TRACK, 1000);
    frame(0, TRACK, 1000);
    chk("idle_state", state, 0);
    chk("idle_score_left", score_left, 0);
    chk("idle_score_right", score_right, 0);

    repeat (70) frame(1, TRACK, TRACK);
    chk("pre_reset_running", game_running, 1);
    #2 reset = 1'b1;
    start_game = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    model_reset();
    @(negedge frame_clk);
    reset = 1'b0;
    repeat (3) frame(0, TRACK, TRACK);
    chk("post_reset_idle", state, 0);
    frame(1, TRACK, TRACK);
    chk("post_reset_serve", state, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
